lane_bringup_ctrl: RTL
======================

# lane_bringup_ctrl

Per-lane receive bring-up controller that sequences one 64B/67B decoder instance: drives its reset, DATA_VALID and PASSTHROUGH inputs, and watches its LOCKED, HEADER_OUT and DATA_OUT outputs. It qualifies word lock, acquires Interlaken metaframe alignment by tracking sync control words, and restarts the decoder when lock times out. It sits between the transceiver gearbox and the lane deskew logic, and provides the per-lane status bits read by CSR.

## Interface
- METAFRAME_LEN, 2048: words per metaframe; legal range 5–65535.
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before the decoder is restarted; must be ≥ 2.
- SYNC_GOOD, 4: consecutive on-time sync words needed to declare alignment.
- SYNC_BAD, 4: consecutive missing or corrupt sync words that drop alignment.
- USER_CLK  in  1  single clock; all logic on its rising edge.
- SYSTEM_RESET_N  in  1  synchronous, active-low reset.
- XCVR_READY  in  1  transceiver receive path ready.
- PASSTHROUGH_REQ  in  1  CSR request to bypass decoding.
- DEC_LOCKED  in  1  decoder word-lock flag.
- DEC_HEADER  in  2  decoder header output.
- DEC_DATA  in  64  decoder data output.
- DEC_RESET  out  1  active-high reset to the decoder.
- DEC_DATA_VALID  out  1  to the decoder DATA_VALID input.
- DEC_PASSTHROUGH  out  1  to the decoder PASSTHROUGH input.
- LANE_ALIGNED  out  1  metaframe alignment achieved.
- WORD_VALID  out  1  DEC_DATA qualified for downstream; equal to LANE_ALIGNED.
- STATE_OUT  out  3  current state encoding.
- RELOCK_COUNT  out  8  number of lock timeouts; saturates at 255.
- SCRAM_STATE  out  58  last captured scrambler state (see Configuration).

## Operation
- Sync word: DEC_HEADER==2'b10 and DEC_DATA==64'h78F678F678F678F6.
- State encodings: RESET_DEC=0, WAIT_XCVR=1, WAIT_LOCK=2, FIND_SYNC=3, CHECK_SYNC=4, ALIGNED=5, PASSTHRU=6.
- RESET_DEC
  - DEC_RESET=1 for exactly 4 cycles, then go to WAIT_XCVR.
- WAIT_XCVR
  - DEC_DATA_VALID=0.
  - Go to WAIT_LOCK when XCVR_READY=1; the lock timer clears on entry.
- WAIT_LOCK
  - DEC_DATA_VALID=1.
  - Go to FIND_SYNC when DEC_LOCKED=1.
  - When the timer reaches LOCK_TIMEOUT-1, go to RESET_DEC and increment RELOCK_COUNT (saturating).
- FIND_SYNC
  - On a sync word, go to CHECK_SYNC with word_ctr=0 and good=1.
- Metaframe check (CHECK_SYNC and ALIGNED)
  - word_ctr increments every cycle.
  - The check fires when word_ctr==METAFRAME_LEN-1; word_ctr then wraps to 0.
- CHECK_SYNC
  - Match: good++. When good reaches SYNC_GOOD, go to ALIGNED with bad=0.
  - Mismatch: go to FIND_SYNC.
- ALIGNED
  - Match: bad=0.
  - Mismatch: bad++. When bad reaches SYNC_BAD, go to FIND_SYNC.
  - A sync word arriving off-schedule is ignored.
- Priority, highest first:
  1. Reset.
  2. PASSTHROUGH_REQ=1: go to PASSTHRU from any state.
  3. XCVR_READY=0 in WAIT_LOCK, FIND_SYNC, CHECK_SYNC or ALIGNED: go to RESET_DEC.
  4. DEC_LOCKED=0 in FIND_SYNC, CHECK_SYNC or ALIGNED: go to WAIT_LOCK (timer cleared).
  5. Sync-word logic.
- PASSTHRU
  - DEC_PASSTHROUGH=1, DEC_DATA_VALID=XCVR_READY, LANE_ALIGNED=0.
  - Go to RESET_DEC when PASSTHROUGH_REQ falls.
- Counter widths: word_ctr and the lock timer are sized with $clog2 of their parameter. good and bad are 3 bits.

## Timing
- Every output is registered and is a function of the registered state (and of XCVR_READY in PASSTHRU).
- Reset values: DEC_RESET=1, DEC_DATA_VALID=0, DEC_PASSTHROUGH=0, LANE_ALIGNED=0, WORD_VALID=0, STATE_OUT=0, RELOCK_COUNT=0, SCRAM_STATE=0.
- After release of SYSTEM_RESET_N, DEC_RESET stays high for 4 more cycles.
- Sync compare is performed on the same cycle the decoder presents the word. LANE_ALIGNED rises 1 cycle after the SYNC_GOOD-th match.
- LANE_ALIGNED falls 1 cycle after the SYNC_BAD-th miss, after DEC_LOCKED drops, or after XCVR_READY drops.
- Reset asserted mid-operation has the same effect as power-on reset.

## Configuration
- LANE_BRINGUP_SCRAM_CAPTURE_EN
  - Defined: in CHECK_SYNC and ALIGNED, the word immediately after an accepted sync word is checked for DEC_HEADER==2'b10 and DEC_DATA[63:58]==6'b001010. On a match, DEC_DATA[57:0] is loaded into SCRAM_STATE one cycle later. A failed check counts as a mismatch, identical to a missing sync word.
  - Undefined: SCRAM_STATE is tied to 0 and the scrambler word is not checked.

## Structure
- Package lane_ctrl_pkg holds the state enum, SYNC_WORD, SCRAM_BLOCK_TYPE, HDR_CTRL=2'b10, and the RESET_DEC hold length of 4.
- Sub-module lane_sync_word_checker owns word_ctr, the on-time sync compare, the optional scrambler capture and the good/bad counters. It reports the events match, miss and reached_good/reached_bad to the main FSM.

## Test plan
- Reset, then XCVR_READY=1 and DEC_LOCKED=1 after 10 cycles, then sync words every 2048 cycles → LANE_ALIGNED=1 one cycle after the 4th sync word; STATE_OUT=5.
- DEC_LOCKED held at 0 for 4096 cycles → DEC_RESET pulses for 4 cycles, RELOCK_COUNT=1; after 300 timeouts RELOCK_COUNT=255.
- While aligned, corrupt 3 sync words then send a good one → stays ALIGNED. Corrupt 4 consecutive → STATE_OUT=3, LANE_ALIGNED=0.
- PASSTHROUGH_REQ=1 in the same cycle as XCVR_READY=0 → PASSTHRU wins with DEC_PASSTHROUGH=1; on release → RESET_DEC.
- With LANE_BRINGUP_SCRAM_CAPTURE_EN defined, a scrambler word carrying state 58'h2AB_CDEF_0123_4567 after a sync word → SCRAM_STATE equals that value; a bad block type counts as a miss.

Source files
------------

// File: rtl/lane_ctrl_pkg.sv
// Shared types and constants for the per-lane receive bring-up controller.
package lane_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_DEC  = 3'd0,
        WAIT_XCVR  = 3'd1,
        WAIT_LOCK  = 3'd2,
        FIND_SYNC  = 3'd3,
        CHECK_SYNC = 3'd4,
        ALIGNED    = 3'd5,
        PASSTHRU   = 3'd6
    } lane_state_e;

    localparam logic [63:0] SYNC_WORD         = 64'h78F6_78F6_78F6_78F6;
    localparam logic [5:0]  SCRAM_BLOCK_TYPE  = 6'b001010;
    localparam logic [1:0]  HDR_CTRL          = 2'b10;
    localparam int unsigned RESET_HOLD_CYCLES = 4;

endpackage

// File: rtl/lane_bringup_ctrl_if.sv
// Decoder-facing and CSR-facing signals of one lane bring-up controller.
interface lane_bringup_ctrl_if;

    logic        XCVR_READY;
    logic        PASSTHROUGH_REQ;
    logic        DEC_LOCKED;
    logic [1:0]  DEC_HEADER;
    logic [63:0] DEC_DATA;
    logic        DEC_RESET;
    logic        DEC_DATA_VALID;
    logic        DEC_PASSTHROUGH;
    logic        LANE_ALIGNED;
    logic        WORD_VALID;
    logic [2:0]  STATE_OUT;
    logic [7:0]  RELOCK_COUNT;
    logic [57:0] SCRAM_STATE;

    modport master (
        input  XCVR_READY, PASSTHROUGH_REQ, DEC_LOCKED, DEC_HEADER, DEC_DATA,
        output DEC_RESET, DEC_DATA_VALID, DEC_PASSTHROUGH, LANE_ALIGNED,
               WORD_VALID, STATE_OUT, RELOCK_COUNT, SCRAM_STATE
    );

    modport slave (
        output XCVR_READY, PASSTHROUGH_REQ, DEC_LOCKED, DEC_HEADER, DEC_DATA,
        input  DEC_RESET, DEC_DATA_VALID, DEC_PASSTHROUGH, LANE_ALIGNED,
               WORD_VALID, STATE_OUT, RELOCK_COUNT, SCRAM_STATE
    );

endinterface

// File: rtl/lane_sync_word_checker.sv
// Metaframe position counter, on-time sync compare and good/bad run counters.
// Optional scrambler-state check/capture under LANE_BRINGUP_SCRAM_CAPTURE_EN.
module lane_sync_word_checker
    import lane_ctrl_pkg::*;
#(
    parameter int unsigned METAFRAME_LEN = 2048,
    parameter int unsigned SYNC_GOOD     = 4,
    parameter int unsigned SYNC_BAD      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  dec_header,
    input  logic [63:0] dec_data,
    input  logic        load,
    input  logic        check_mode,
    input  logic        align_mode,
    output logic        sync_hit,
    output logic        match,
    output logic        miss,
    output logic        reached_good,
    output logic        reached_bad,
    output logic [57:0] scram_state
);

    localparam int unsigned     WC_W      = $clog2(METAFRAME_LEN);
    localparam logic [WC_W-1:0] WC_LAST   = WC_W'(METAFRAME_LEN - 1);
    localparam logic [2:0]      GOOD_LAST = 3'(SYNC_GOOD - 1);
    localparam logic [2:0]      BAD_LAST  = 3'(SYNC_BAD - 1);

    logic [WC_W-1:0] word_ctr_q, word_ctr_d;
    logic [2:0]      good_q, good_d;
    logic [2:0]      bad_q, bad_d;
    logic            active;
    logic            on_time;
    logic            scram_fail;

    assign active       = check_mode || align_mode;
    assign on_time      = (word_ctr_q == WC_LAST);
    assign sync_hit     = (dec_header == HDR_CTRL) && (dec_data == SYNC_WORD);
    assign match        = active && on_time && sync_hit;
    assign miss         = active && ((on_time && !sync_hit) || scram_fail);
    assign reached_good = (good_q == GOOD_LAST);
    assign reached_bad  = (bad_q == BAD_LAST);

`ifdef LANE_BRINGUP_SCRAM_CAPTURE_EN
    logic        scram_pend_q, scram_pend_d;
    logic [57:0] scram_state_q, scram_state_d;
    logic        scram_ok;

    // The word right after an accepted sync word must be a scrambler-state block.
    assign scram_ok   = (dec_header == HDR_CTRL) && (dec_data[63:58] == SCRAM_BLOCK_TYPE);
    assign scram_fail = active && scram_pend_q && !scram_ok;

    always_comb begin
        scram_pend_d  = load || match;
        scram_state_d = scram_state_q;
        if (active && scram_pend_q && scram_ok) begin
            scram_state_d = dec_data[57:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scram_pend_q  <= 1'b0;
            scram_state_q <= '0;
        end else begin
            scram_pend_q  <= scram_pend_d;
            scram_state_q <= scram_state_d;
        end
    end

    assign scram_state = scram_state_q;
`else
    assign scram_fail  = 1'b0;
    assign scram_state = '0;
`endif

    always_comb begin
        word_ctr_d = word_ctr_q;
        good_d     = good_q;
        bad_d      = bad_q;
        if (load) begin
            word_ctr_d = '0;
            good_d     = 3'd1;
        end else if (active) begin
            word_ctr_d = on_time ? '0 : word_ctr_q + 1'b1;
        end
        if (check_mode && match) begin
            good_d = good_q + 3'd1;
            if (reached_good) begin
                bad_d = 3'd0;
            end
        end
        if (align_mode) begin
            if (match) begin
                bad_d = 3'd0;
            end else if (miss) begin
                bad_d = bad_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_ctr_q <= '0;
            good_q     <= 3'd0;
            bad_q      <= 3'd0;
        end else begin
            word_ctr_q <= word_ctr_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

endmodule

// File: rtl/lane_bringup_ctrl.sv
// Per-lane receive bring-up FSM: decoder reset, word-lock wait, metaframe alignment.
// Define LANE_BRINGUP_SCRAM_CAPTURE_EN to check and capture the scrambler state word.
module lane_bringup_ctrl
    import lane_ctrl_pkg::*;
#(
    parameter int unsigned METAFRAME_LEN = 2048,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned SYNC_GOOD     = 4,
    parameter int unsigned SYNC_BAD      = 4
) (
    input  logic                USER_CLK,
    input  logic                SYSTEM_RESET_N,
    lane_bringup_ctrl_if.master lane
);

    localparam int unsigned      TMR_W     = $clog2(LOCK_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       HOLD_LAST = 2'(RESET_HOLD_CYCLES - 1);

    lane_state_e      state_q, state_d;
    logic [1:0]       hold_q, hold_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       relock_q, relock_d;
    logic             dec_reset_q, dec_reset_d;
    logic             data_valid_q, data_valid_d;
    logic             passthrough_q, passthrough_d;
    logic             aligned_q, aligned_d;
    logic             sync_ok, load, check_mode, align_mode;
    logic             sync_hit, match, miss, reached_good, reached_bad;

    // Sync-word logic only acts when no higher-priority condition is present.
    assign sync_ok    = !lane.PASSTHROUGH_REQ && lane.XCVR_READY && lane.DEC_LOCKED;
    assign load       = (state_q == FIND_SYNC) && sync_ok && sync_hit;
    assign check_mode = (state_q == CHECK_SYNC) && sync_ok;
    assign align_mode = (state_q == ALIGNED) && sync_ok;

    lane_sync_word_checker #(
        .METAFRAME_LEN (METAFRAME_LEN),
        .SYNC_GOOD     (SYNC_GOOD),
        .SYNC_BAD      (SYNC_BAD)
    ) u_checker (
        .clk          (USER_CLK),
        .rst_n        (SYSTEM_RESET_N),
        .dec_header   (lane.DEC_HEADER),
        .dec_data     (lane.DEC_DATA),
        .load         (load),
        .check_mode   (check_mode),
        .align_mode   (align_mode),
        .sync_hit     (sync_hit),
        .match        (match),
        .miss         (miss),
        .reached_good (reached_good),
        .reached_bad  (reached_bad),
        .scram_state  (lane.SCRAM_STATE)
    );

    always_comb begin
        state_d  = state_q;
        relock_d = relock_q;
        if (lane.PASSTHROUGH_REQ) begin
            state_d = PASSTHRU;
        end else begin
            case (state_q)
                RESET_DEC: if (hold_q == HOLD_LAST) state_d = WAIT_XCVR;
                WAIT_XCVR: if (lane.XCVR_READY) state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (!lane.XCVR_READY) begin
                        state_d = RESET_DEC;
                    end else if (lane.DEC_LOCKED) begin
                        state_d = FIND_SYNC;
                    end else if (timer_q == TMR_LAST) begin
                        state_d = RESET_DEC;
                        if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                    end
                end
                FIND_SYNC, CHECK_SYNC, ALIGNED: begin
                    if (!lane.XCVR_READY) begin
                        state_d = RESET_DEC;
                    end else if (!lane.DEC_LOCKED) begin
                        state_d = WAIT_LOCK;
                    end else if (state_q == FIND_SYNC) begin
                        if (sync_hit) state_d = CHECK_SYNC;
                    end else if (state_q == CHECK_SYNC) begin
                        if (match && reached_good) state_d = ALIGNED;
                        else if (miss)             state_d = FIND_SYNC;
                    end else if (miss && reached_bad) begin
                        state_d = FIND_SYNC;
                    end
                end
                default: state_d = RESET_DEC;
            endcase
        end

        // Hold and lock timers restart whenever their state is (re)entered.
        hold_d  = (state_q == RESET_DEC && state_d == RESET_DEC) ? hold_q + 2'd1 : 2'd0;
        timer_d = (state_q == WAIT_LOCK && state_d == WAIT_LOCK) ? timer_q + 1'b1 : '0;

        dec_reset_d   = (state_d == RESET_DEC);
        passthrough_d = (state_d == PASSTHRU);
        aligned_d     = (state_d == ALIGNED);
        data_valid_d  = (state_d == PASSTHRU) ? lane.XCVR_READY :
                        (state_d == WAIT_LOCK || state_d == FIND_SYNC ||
                         state_d == CHECK_SYNC || state_d == ALIGNED);
    end

    always_ff @(posedge USER_CLK) begin
        if (!SYSTEM_RESET_N) begin
            state_q       <= RESET_DEC;
            hold_q        <= 2'd0;
            timer_q       <= '0;
            relock_q      <= 8'd0;
            dec_reset_q   <= 1'b1;
            data_valid_q  <= 1'b0;
            passthrough_q <= 1'b0;
            aligned_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            timer_q       <= timer_d;
            relock_q      <= relock_d;
            dec_reset_q   <= dec_reset_d;
            data_valid_q  <= data_valid_d;
            passthrough_q <= passthrough_d;
            aligned_q     <= aligned_d;
        end
    end

    assign lane.DEC_RESET       = dec_reset_q;
    assign lane.DEC_DATA_VALID  = data_valid_q;
    assign lane.DEC_PASSTHROUGH = passthrough_q;
    assign lane.LANE_ALIGNED    = aligned_q;
    assign lane.WORD_VALID      = aligned_q;
    assign lane.STATE_OUT       = state_q;
    assign lane.RELOCK_COUNT    = relock_q;

endmodule
